// File: rtl/chronos_mem_pkg.sv
// Shared types and defaults for the Chronos unified-memory arbiter, inst_mem and core top.
package chronos_mem_pkg;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } owner_t;

    function automatic arb_state_t busy_state(input owner_t owner);
        return (owner == OWNER_DM) ? BUSY_DM : BUSY_IF;
    endfunction

endpackage

// File: rtl/mem_arb_lat_timer.sv
// Loadable down-counter that tracks the remaining memory latency; done is high at zero.
module mem_arb_lat_timer #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load wins over counting; the counter parks at zero between accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (IF) and data memory (DM),
// with DM priority and a starvation counter that eventually forces an IF access.
module mem_port_arbiter
    import chronos_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_dm
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT);

    arb_state_t       state_q, state_d;
    owner_t           winner;
    logic             dm_win, if_win, issue, lat_done;
    logic [STV_W-1:0] starve_cnt;

    // IF is forced only once DM has won STARVE_MAX times in a row while IF was waiting.
    always_comb begin
        dm_win = dm_req & ~(if_req & (starve_cnt == STARVE_LIM));
        if_win = if_req & ~dm_win;
        winner = dm_win ? OWNER_DM : OWNER_IF;
        issue  = (state_q == IDLE) & (dm_win | if_win);
    end

    always_comb begin
        state_d   = state_q;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) state_d = busy_state(winner);
            end
            BUSY_IF: begin
                if (lat_done) begin
                    if_rvalid = 1'b1;
                    state_d   = IDLE;
                end
            end
            BUSY_DM: begin
                if (lat_done) begin
                    dm_rvalid = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access fields are captured only at the win edge and then held until the next win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            mem_req <= issue;
            if (issue) begin
                if (winner == OWNER_DM) begin
                    mem_we    <= dm_we;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                    mem_be    <= dm_be;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    mem_be    <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state_q == IDLE) begin
            if (!if_req || if_win) begin
                starve_cnt <= '0;
            end else if (dm_win && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    mem_arb_lat_timer #(
        .MAX (MEM_LAT),
        .W   (LAT_W)
    ) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (issue),
        .load_val (LAT_LOAD),
        .done     (lat_done)
    );

    // mem_req is high only in the first BUSY cycle, which doubles as the grant pulse.
    assign if_gnt   = mem_req & (state_q == BUSY_IF);
    assign dm_gnt   = mem_req & (state_q == BUSY_DM);
    assign if_rdata = if_rvalid ? mem_rdata : '0;
    assign dm_rdata = (dm_rvalid & ~mem_we) ? mem_rdata : '0;
    assign stall_if = if_req & ~if_rvalid;
    assign stall_dm = dm_req & ~dm_rvalid;

endmodule
